// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Merges ALU and queued LSU results onto one register-file write
//            port with WAW kill of stale loads. WB_SCOREBOARD_EN adds pending_o.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [63:0] alu_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [63:0] lsu_wdata_i,
    output logic        reg_wen_o,
    output logic [4:0]  reg_waddr_o,
    output logic [63:0] reg_wdata_o
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [31:0] pending_o
`endif
);

    localparam int              c_PW   = $clog2(FIFO_DEPTH);
    localparam int              c_CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0] r_live;
    logic [4:0]            r_addr [FIFO_DEPTH];
    logic [63:0]           r_data [FIFO_DEPTH];
    logic [c_PW-1:0]       r_wr_ptr;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;

    logic                  w_alu_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_live;
    logic [FIFO_DEPTH-1:0] w_live_nxt;

    // A full FIFO refuses pushes even if a pop happens in the same cycle.
    assign lsu_ready_o = rst & (r_count != c_FULL);
    assign w_alu_acc   = alu_valid_i & (alu_waddr_i != 5'd0);
    assign w_push      = lsu_valid_i & lsu_ready_o & (lsu_waddr_i != 5'd0);
    assign w_pop       = ~w_alu_acc & (r_count != '0);
    assign w_push_live = ~(w_alu_acc & (alu_waddr_i == lsu_waddr_i));

    // Live bit is cleared on pop too, so live implies occupied.
    always_comb begin
        w_live_nxt = r_live;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_alu_acc && (r_addr[i] == alu_waddr_i))
                w_live_nxt[i] = 1'b0;
            if (w_pop && (r_rd_ptr == c_PW'(i)))
                w_live_nxt[i] = 1'b0;
            if (w_push && (r_wr_ptr == c_PW'(i)))
                w_live_nxt[i] = w_push_live;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_live      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= 64'd0;
        end else begin
            r_live <= w_live_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            reg_wen_o <= w_alu_acc | (w_pop & r_live[r_rd_ptr]);
            if (w_alu_acc) begin
                reg_waddr_o <= alu_waddr_i;
                reg_wdata_o <= alu_wdata_i;
            end else if (w_pop) begin
                reg_waddr_o <= r_addr[r_rd_ptr];
                reg_wdata_o <= r_data[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= lsu_waddr_i;
            r_data[r_wr_ptr] <= lsu_wdata_i;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [4:0]  w_addr_nxt [FIFO_DEPTH];
    logic [31:0] w_pend_nxt;

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_addr_nxt[i] = (w_push && (r_wr_ptr == c_PW'(i))) ? lsu_waddr_i : r_addr[i];
            if (w_live_nxt[i])
                w_pend_nxt[w_addr_nxt[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            pending_o <= '0;
        else
            pending_o <= w_pend_nxt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed bench for wb_arbiter with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_waddr_i = 5'd0;
    logic [63:0] alu_wdata_i = 64'd0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i = 5'd0;
    logic [63:0] lsu_wdata_i = 64'd0;
    logic        reg_wen_o;
    logic [4:0]  reg_waddr_o;
    logic [63:0] reg_wdata_o;
`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending_o;
`endif

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.FIFO_DEPTH(c_DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_waddr_i (alu_waddr_i),
        .alu_wdata_i (alu_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .reg_wen_o   (reg_wen_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o)
`ifdef WB_SCOREBOARD_EN
        ,
        .pending_o   (pending_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-order list of queued loads.
    typedef struct {
        bit          live;
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_ok = 1'b0;
    bit          m_wen = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [63:0] m_data = 64'd0;

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].a] = 1'b1;
        return p;
    endfunction

    always @(posedge clk) begin
        bit   alu_w;
        bit   room;
        ent_t e;
        m_ok = 1'b1;
        if (!rst) begin
            q.delete();
            m_wen = 1'b0;
        end else begin
            alu_w = alu_valid_i && (alu_waddr_i != 0);
            room  = (q.size() != c_DEPTH);
            if (alu_w)
                foreach (q[i]) if (q[i].a == alu_waddr_i) q[i].live = 1'b0;
            if (alu_w) begin
                m_wen = 1'b1; m_addr = alu_waddr_i; m_data = alu_wdata_i;
            end else if (q.size() != 0) begin
                e = q.pop_front();
                m_wen = e.live; m_addr = e.a; m_data = e.d;
            end else begin
                m_wen = 1'b0;
            end
            if (lsu_valid_i && room && (lsu_waddr_i != 0)) begin
                e.live = !(alu_w && (alu_waddr_i == lsu_waddr_i));
                e.a = lsu_waddr_i; e.d = lsu_wdata_i;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_wen", {63'd0, reg_wen_o}, {63'd0, m_wen});
            if (m_wen) begin
                chk("model_waddr", {59'd0, reg_waddr_o}, {59'd0, m_addr});
                chk("model_wdata", reg_wdata_o, m_data);
            end
            chk("model_ready", {63'd0, lsu_ready_o}, {63'd0, rst && (q.size() != c_DEPTH)});
`ifdef WB_SCOREBOARD_EN
            chk("model_pending", {32'd0, pending_o}, {32'd0, m_pending()});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input bit v, input logic [4:0] a, input logic [63:0] d);
        alu_valid_i = v; alu_waddr_i = a; alu_wdata_i = d;
    endtask

    task automatic lsu(input bit v, input logic [4:0] a, input logic [63:0] d);
        lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask

    task automatic exp_write(input string nm, input logic [4:0] a, input logic [63:0] d);
        chk({nm, "_wen"}, {63'd0, reg_wen_o}, 64'd1);
        chk({nm, "_addr"}, {59'd0, reg_waddr_o}, {59'd0, a});
        chk({nm, "_data"}, reg_wdata_o, d);
    endtask

    initial begin
        // Reset held with ALU activity
        alu(1'b1, 5'd3, 64'h33);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_wen", {63'd0, reg_wen_o}, 64'd0);
            chk("rst_ready", {63'd0, lsu_ready_o}, 64'd0);
        end
        rst = 1'b1;
        alu(1'b0, 5'd0, 64'd0);
        step();
        chk("post_rst_ready", {63'd0, lsu_ready_o}, 64'd1);
        chk("post_rst_wen", {63'd0, reg_wen_o}, 64'd0);

        // ALU pass-through and x0 filter
        alu(1'b1, 5'd5, 64'h1234);
        step();
        exp_write("alu_x5", 5'd5, 64'h1234);
        alu(1'b1, 5'd0, 64'hdead);
        step();
        chk("alu_x0_wen", {63'd0, reg_wen_o}, 64'd0);

        // Fill the queue under ALU starvation
        for (int k = 0; k < 4; k++) begin
            alu(1'b1, 5'd1, 64'h100 + 64'(k));
            lsu(1'b1, 5'(10 + k), 64'hA0 + 64'(k));
            step();
        end
        lsu(1'b0, 5'd0, 64'd0);
        chk("full_ready", {63'd0, lsu_ready_o}, 64'd0);
        alu(1'b0, 5'd0, 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            exp_write("drain", 5'(10 + k), 64'hA0 + 64'(k));
        end
        chk("drained_ready", {63'd0, lsu_ready_o}, 64'd1);

        // ALU wins over a queued head
        lsu(1'b1, 5'd7, 64'hAA);
        step();
        lsu(1'b0, 5'd0, 64'd0);
        alu(1'b1, 5'd8, 64'hBB);
        step();
        exp_write("arb_alu", 5'd8, 64'hBB);
        alu(1'b0, 5'd0, 64'd0);
        step();
        exp_write("arb_lsu", 5'd7, 64'hAA);

        // WAW kill of a queued load
        lsu(1'b1, 5'd9, 64'h11);
        step();
`ifdef WB_SCOREBOARD_EN
        chk("pend9_set", {63'd0, pending_o[9]}, 64'd1);
`endif
        lsu(1'b0, 5'd0, 64'd0);
        alu(1'b1, 5'd9, 64'h22);
        step();
        exp_write("waw_alu", 5'd9, 64'h22);
`ifdef WB_SCOREBOARD_EN
        chk("pend9_clr", {63'd0, pending_o[9]}, 64'd0);
`endif
        alu(1'b0, 5'd0, 64'd0);
        step();
        chk("waw_bubble", {63'd0, reg_wen_o}, 64'd0);

        // Same-cycle kill: push enqueued dead
        alu(1'b1, 5'd12, 64'h55);
        lsu(1'b1, 5'd12, 64'h66);
        step();
        exp_write("same_alu", 5'd12, 64'h55);
        alu(1'b0, 5'd0, 64'd0);
        lsu(1'b0, 5'd0, 64'd0);
        step();
        chk("same_bubble", {63'd0, reg_wen_o}, 64'd0);

        // Ten back-to-back loads wrap the pointers twice
        for (int k = 0; k < 10; k++) begin
            lsu(1'b1, 5'(16 + k), 64'hC000 + 64'(k * 7));
            step();
            if (k > 0) exp_write("wrap", 5'(16 + k - 1), 64'hC000 + 64'((k - 1) * 7));
        end
        lsu(1'b0, 5'd0, 64'd0);
        step();
        exp_write("wrap_last", 5'd25, 64'hC000 + 64'd63);

        // Reset with three queued loads
        alu(1'b1, 5'd2, 64'h2);
        for (int k = 0; k < 3; k++) begin
            lsu(1'b1, 5'(20 + k), 64'hE0 + 64'(k));
            step();
        end
        alu(1'b0, 5'd0, 64'd0);
        lsu(1'b0, 5'd0, 64'd0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_rst_wen", {63'd0, reg_wen_o}, 64'd0);
            chk("mid_rst_ready", {63'd0, lsu_ready_o}, 64'd1);
        end

        // Mixed traffic checked against the model only
        for (int k = 0; k < 200; k++) begin
            alu(($urandom % 3) == 0, 5'($urandom % 5) + ((($urandom % 4) == 0) ? 5'd9 : 5'd0),
                64'($urandom));
            lsu(($urandom % 2) == 0, 5'($urandom % 5) + ((($urandom % 4) == 0) ? 5'd9 : 5'd0),
                64'($urandom));
            step();
        end
        alu(1'b0, 5'd0, 64'd0);
        lsu(1'b0, 5'd0, 64'd0);
        for (int k = 0; k < 8; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory side and the register file write port. It merges single-cycle ALU results with multi-cycle LSU results into the single write port (waddr/wdata/wen), one write per cycle. LSU results wait in a small FIFO. Write-after-write ordering is preserved by killing stale queued entries. The block drives the register file's write inputs directly from registered outputs.

## Interface
- FIFO_DEPTH, 4, LSU result queue entries; power of two, ≥ 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alu_valid_i  in  1  ALU result valid this cycle; always accepted, no backpressure
- alu_waddr_i  in  5  ALU destination register
- alu_wdata_i  in  64  ALU result
- lsu_valid_i  in  1  LSU result offered
- lsu_ready_o  out  1  FIFO can accept; push = lsu_valid_i & lsu_ready_o
- lsu_waddr_i  in  5  LSU destination register
- lsu_wdata_i  in  64  LSU load data, already sign/zero-extended to 64 bits
- reg_wen_o  out  1  register file write enable (registered)
- reg_waddr_o  out  5  register file write address (registered)
- reg_wdata_o  out  64  register file write data (registered)
- pending_o  out  32  bit i set = live queued write to xi (only with WB_SCOREBOARD_EN)

## Operation
- Filtering: writes to x0 from either source are dropped at entry. An ALU write to x0 produces no write. An LSU push to x0 completes the handshake but nothing is enqueued.
- FIFO:
  - Each entry holds {live, waddr, wdata}.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth.
  - A count register tracks occupancy (0..FIFO_DEPTH).
  - lsu_ready_o = rst & (count != FIFO_DEPTH). When full, a pop in the same cycle does not free a slot for a push in that cycle.
- Arbitration (one output slot per cycle):
  - A valid non-x0 ALU write has priority and takes the slot.
  - Otherwise, if count != 0, the head entry is popped.
  - A popped entry with live = 1 produces a write; with live = 0 it produces a bubble (reg_wen_o = 0).
- WAW kill:
  - An accepted ALU write to rd clears live on every queued entry with waddr == rd.
  - If an LSU push to the same rd happens in the same cycle, that entry is enqueued with live = 0. The ALU result is younger in program order.
  - Dead entries still occupy slots until popped.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Reset mid-operation: the FIFO empties, all queued entries are lost, and no write issues in the cycle after reset is released.

## Timing
- Reset values: reg_wen_o = 0, reg_waddr_o = 0, reg_wdata_o = 0, lsu_ready_o = 0 (during reset), pending_o = 0, count = 0, pointers = 0.
- ALU latency: accepted in cycle N → reg_wen_o high in N+1 with the same address and data.
- LSU latency: pushed in cycle N into an empty FIFO with no ALU write in N+1 → popped in N+1 → reg_wen_o high in N+2.
- ALU starvation of the FIFO is allowed. The LSU sees backpressure through lsu_ready_o only.
- Outputs change only on the rising clk edge.

## Configuration
- WB_SCOREBOARD_EN defined:
  - pending_o exists.
  - It is a register holding the OR over live entries of the one-hot decode of their waddr.
  - It is updated on every push, pop and kill, and is visible the cycle after the event.
  - ID uses it to stall readers of in-flight load destinations.
- WB_SCOREBOARD_EN undefined:
  - The pending_o port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold rst = 0 for 3 cycles with alu_valid_i = 1 → reg_wen_o = 0 and lsu_ready_o = 0 throughout. After release, lsu_ready_o = 1.
- **ALU pass-through:** ALU x5 = 0x1234 at cycle N → reg_wen_o = 1, reg_waddr_o = 5, reg_wdata_o = 0x1234 at N+1. ALU write to x0 → reg_wen_o = 0.
- **LSU queue and backpressure:**
  - Hold alu_valid_i = 1 (rd = x1) and push 4 LSU writes x10..x13.
  - lsu_ready_o drops to 0 after the 4th push.
  - Drop alu_valid_i → x10..x13 written in order on 4 consecutive cycles, then lsu_ready_o = 1.
- **Arbitration:** LSU x7 = 0xAA queued, ALU x8 = 0xBB in the same cycle as the head would pop → x8 written first, x7 written the next cycle.
- **WAW kill:**
  - Queue LSU x9 = 0x11, then ALU x9 = 0x22 while the LSU entry is still queued.
  - Only 0x22 is written to x9. The dead slot yields a reg_wen_o = 0 cycle.
  - With WB_SCOREBOARD_EN, pending_o[9] is 1 after the push and clears the cycle after the kill.
- **Wrap and mid-operation reset:**
  - Push and pop 10 entries so the pointers wrap twice → all written in order with correct data.
  - Assert rst with 3 entries queued → none are written after release, and count = 0.
